// File: rtl/vmicro16_apb_rr_arbiter.sv
// vmicro16_apb_rr_arbiter: round-robin sharing of one upstream APB master port among NMASTERS cores.
// Define VMICRO16_APB_ARB_TIMEOUT_EN to force completion of ACCESS after TIMEOUT_CYCLES wait cycles.
module vmicro16_apb_rr_arbiter #(
    parameter int BUS_WIDTH      = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NMASTERS       = 4,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int GW            = ($clog2(NMASTERS) > 0) ? $clog2(NMASTERS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NMASTERS*BUS_WIDTH-1:0]  S_PADDR,
    input  logic [NMASTERS-1:0]            S_PWRITE,
    input  logic [NMASTERS-1:0]            S_PSELx,
    input  logic [NMASTERS-1:0]            S_PENABLE,
    input  logic [NMASTERS*DATA_WIDTH-1:0] S_PWDATA,
    output logic [NMASTERS*DATA_WIDTH-1:0] S_PRDATA,
    output logic [NMASTERS-1:0]            S_PREADY,
    output logic [BUS_WIDTH-1:0]           M_PADDR,
    output logic                           M_PWRITE,
    output logic                           M_PSELx,
    output logic                           M_PENABLE,
    output logic [DATA_WIDTH-1:0]          M_PWDATA,
    input  logic [DATA_WIDTH-1:0]          M_PRDATA,
    input  logic                           M_PREADY,
    output logic [GW-1:0]                  grant_id,
    output logic                           busy,
    output logic                           timeout_err
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d, last_q, last_d;
    logic [BUS_WIDTH-1:0]  paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [GW-1:0]         win, idx;
    logic                  found, done, tout;
    logic                  unused_ok;

    assign unused_ok = ^{S_PENABLE, TIMEOUT_CYCLES[0]};

    // First requester after the last winner, wrapping modulo NMASTERS.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NMASTERS; k++) begin
            idx = GW'((int'(last_q) + k) % NMASTERS);
            if (!found && S_PSELx[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef VMICRO16_APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tout  = (state_q == ACCESS) && !M_PREADY && (cnt_q == CW'(TIMEOUT_CYCLES));
    assign cnt_d = (state_q == SETUP) ? '0 :
                   ((state_q == ACCESS) && !M_PREADY && !tout) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign tout = 1'b0;
`endif

    assign done        = (state_q == ACCESS) && (M_PREADY || tout);
    assign timeout_err = tout;
    assign busy        = (state_q == SETUP) || (state_q == ACCESS);
    assign M_PSELx     = busy;
    assign M_PENABLE   = state_q == ACCESS;
    assign M_PADDR     = paddr_q;
    assign M_PWRITE    = pwrite_q;
    assign M_PWDATA    = pwdata_q;
    assign grant_id    = grant_q;

    always_comb begin
        S_PREADY = '0;
        S_PRDATA = '0;
        if (done) begin
            S_PREADY[grant_q] = 1'b1;
            S_PRDATA[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] = M_PREADY ? M_PRDATA : '1;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        if (state_q == IDLE && found) begin
            state_d  = SETUP;
            grant_d  = win;
            last_d   = win;
            paddr_d  = S_PADDR[int'(win)*BUS_WIDTH +: BUS_WIDTH];
            pwrite_d = S_PWRITE[win];
            pwdata_d = S_PWDATA[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        end else if (state_q == SETUP) begin
            state_d = ACCESS;
        end else if (done || state_q == 2'd3) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= GW'(NMASTERS - 1);
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
        end
    end
endmodule

// File: tb/tb_vmicro16_apb_rr_arbiter.sv
// tb_vmicro16_apb_rr_arbiter: directed scenarios plus randomized traffic against a transfer-level model.
`timescale 1ns/1ps
module tb_vmicro16_apb_rr_arbiter;
    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NM*AW-1:0]  S_PADDR = '0;
    logic [NM-1:0]     S_PWRITE = '0, S_PSELx = '0, S_PENABLE = '0;
    logic [NM*DW-1:0]  S_PWDATA = '0;
    logic [NM*DW-1:0]  S_PRDATA;
    logic [NM-1:0]     S_PREADY;
    logic [AW-1:0]     M_PADDR;
    logic              M_PWRITE, M_PSELx, M_PENABLE, M_PREADY;
    logic [DW-1:0]     M_PWDATA, M_PRDATA;
    logic [1:0]        grant_id;
    logic              busy, timeout_err;

    int checks = 0;
    int errors = 0;
    int ws_next = 0;
    int ws_cur = 0;
    int acc_cnt = 0;
    logic [DW-1:0] rd_pat = '0;

    always #5 clk = ~clk;

    vmicro16_apb_rr_arbiter dut (
        .clk(clk), .reset(reset),
        .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE),
        .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY),
        .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
        .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    // Upstream slave: ws_cur wait states per transfer, picked up while SETUP is on the bus.
    assign M_PRDATA = rd_pat;
    assign M_PREADY = M_PENABLE && (acc_cnt == ws_cur);
    always @(posedge clk) begin
        if (M_PSELx && !M_PENABLE) ws_cur <= ws_next;
        acc_cnt <= (M_PENABLE && !M_PREADY) ? acc_cnt + 1 : 0;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [NM-1:0] r, input int l);
        for (int k = 1; k <= NM; k++)
            if (r[(l + k) % NM]) return (l + k) % NM;
        return 0;
    endfunction

    task automatic test_reset;
        reset = 1'b0;
        S_PSELx = '0;
        step;
        step;
        checks++;
        if ({M_PSELx, M_PENABLE, M_PWRITE, busy, timeout_err} !== 5'b0)
            $display("FAIL reset_ctl: got %b want 00000", {M_PSELx, M_PENABLE, M_PWRITE, busy, timeout_err});
        checks++;
        if (M_PADDR !== '0 || M_PWDATA !== '0)
            $display("FAIL reset_bus: got paddr=%h pwdata=%h want 0 0", M_PADDR, M_PWDATA);
        checks++;
        if (S_PREADY !== '0 || S_PRDATA !== '0 || grant_id !== 2'd0)
            $display("FAIL reset_slave: got pready=%b prdata=%h gid=%0d want 0 0 0", S_PREADY, S_PRDATA, grant_id);
        errors += ({M_PSELx, M_PENABLE, M_PWRITE, busy, timeout_err} !== 5'b0) ? 1 : 0;
        errors += (M_PADDR !== '0 || M_PWDATA !== '0) ? 1 : 0;
        errors += (S_PREADY !== '0 || S_PRDATA !== '0 || grant_id !== 2'd0) ? 1 : 0;
        reset = 1'b1;
    endtask

    task automatic test_single_read;
        ws_next = 0;
        rd_pat = 32'h1234;
        S_PADDR[2*AW +: AW] = 32'h8004;
        S_PWRITE[2] = 1'b0;
        S_PSELx = 4'b0100;
        checks++;
        if (M_PSELx !== 1'b0) begin
            errors++;
            $display("FAIL single_cycle0: got psel=%b want 0", M_PSELx);
        end
        step;
        S_PENABLE[2] = 1'b1;
        checks++;
        if ({M_PSELx, M_PENABLE} !== 2'b10 || M_PADDR !== 32'h8004 || M_PWRITE !== 1'b0 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL single_setup: got sel/en=%b paddr=%h wr=%b gid=%0d want 10 8004 0 2",
                     {M_PSELx, M_PENABLE}, M_PADDR, M_PWRITE, grant_id);
        end
        step;
        checks++;
        if ({M_PSELx, M_PENABLE} !== 2'b11) begin
            errors++;
            $display("FAIL single_access: got sel/en=%b want 11", {M_PSELx, M_PENABLE});
        end
        checks++;
        if (S_PREADY !== 4'b0100) begin
            errors++;
            $display("FAIL single_pready: got %b want 0100", S_PREADY);
        end
        checks++;
        if (S_PRDATA !== {32'h0, 32'h1234, 64'h0}) begin
            errors++;
            $display("FAIL single_prdata: got %h want %h", S_PRDATA, {32'h0, 32'h1234, 64'h0});
        end
        S_PSELx = '0;
        S_PENABLE = '0;
        step;
        checks++;
        if ({M_PSELx, M_PENABLE, busy} !== 3'b0 || S_PREADY !== '0 || S_PRDATA !== '0) begin
            errors++;
            $display("FAIL single_idle: got sel/en/busy=%b pready=%b want 000 0000", {M_PSELx, M_PENABLE, busy}, S_PREADY);
        end
    endtask

    task automatic test_all_four;
        int n = 0;
        int prev = 0;
        int k;
        reset = 1'b0;
        step;
        reset = 1'b1;
        ws_next = 0;
        S_PSELx = 4'b1111;
        for (int c = 0; c < 20 && n < 4; c++) begin
            step;
            if (S_PREADY !== '0) begin
                k = -1;
                for (int i = 0; i < NM; i++) if (S_PREADY[i]) k = i;
                checks++;
                if (k != n || grant_id !== 2'(n)) begin
                    errors++;
                    $display("FAIL all4_order: got master=%0d gid=%0d want %0d", k, grant_id, n);
                end
                if (n > 0) begin
                    checks++;
                    if (c - prev != 3) begin
                        errors++;
                        $display("FAIL all4_spacing: got %0d cycles want 3", c - prev);
                    end
                end
                prev = c;
                if (k >= 0) S_PSELx[k] = 1'b0;
                n++;
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL all4_count: got %0d completions want 4", n);
        end
        S_PSELx = '0;
        step;
    endtask

    task automatic test_alternation;
        int exp_seq[4] = '{1, 3, 1, 3};
        int n = 0;
        int k;
        S_PSELx = 4'b1010;
        for (int c = 0; c < 30 && n < 4; c++) begin
            step;
            if (S_PREADY !== '0) begin
                k = -1;
                for (int i = 0; i < NM; i++) if (S_PREADY[i]) k = i;
                checks++;
                if (k != exp_seq[n]) begin
                    errors++;
                    $display("FAIL alt_order[%0d]: got master=%0d want %0d", n, k, exp_seq[n]);
                end
                n++;
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL alt_count: got %0d completions want 4", n);
        end
        S_PSELx = '0;
        step;
        step;
    endtask

    task automatic test_wait_write;
        int pulses = 0;
        ws_next = 3;
        S_PADDR[0 +: AW] = 32'h8010;
        S_PWDATA[0 +: DW] = 32'hCAFE;
        S_PWRITE[0] = 1'b1;
        S_PSELx = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            step;
            S_PADDR[0 +: AW] = $urandom;
            S_PWDATA[0 +: DW] = $urandom;
            S_PWRITE[0] = 1'b0;
            if (c <= 5) begin
                checks++;
                if (M_PSELx !== 1'b1 || M_PADDR !== 32'h8010 || M_PWDATA !== 32'hCAFE || M_PWRITE !== 1'b1) begin
                    errors++;
                    $display("FAIL wait_hold[%0d]: got sel=%b paddr=%h pwdata=%h wr=%b want 1 8010 cafe 1",
                             c, M_PSELx, M_PADDR, M_PWDATA, M_PWRITE);
                end
                checks++;
                if (S_PREADY !== ((c == 5) ? 4'b0001 : 4'b0000)) begin
                    errors++;
                    $display("FAIL wait_pready[%0d]: got %b want %b", c, S_PREADY, (c == 5) ? 4'b0001 : 4'b0000);
                end
                if (S_PREADY[0]) begin
                    pulses++;
                    S_PSELx = '0;
                end
            end else begin
                checks++;
                if (M_PSELx !== 1'b0 || pulses != 1) begin
                    errors++;
                    $display("FAIL wait_end: got sel=%b pulses=%0d want 0 1", M_PSELx, pulses);
                end
            end
        end
        S_PSELx = '0;
    endtask

    task automatic test_reset_mid;
        ws_next = 5;
        S_PSELx = 4'b0010;
        step;
        step;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({M_PSELx, M_PENABLE, busy} !== 3'b0 || S_PREADY !== '0 || S_PRDATA !== '0 ||
            M_PADDR !== '0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL midreset_async: got sel/en/busy=%b pready=%b paddr=%h gid=%0d want 000 0000 0 0",
                     {M_PSELx, M_PENABLE, busy}, S_PREADY, M_PADDR, grant_id);
        end
        S_PSELx = 4'b0011;
        step;
        checks++;
        if (S_PREADY !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_held: got pready=%b busy=%b want 0000 0", S_PREADY, busy);
        end
        reset = 1'b1;
        step;
        checks++;
        if (grant_id !== 2'd0 || M_PSELx !== 1'b1) begin
            errors++;
            $display("FAIL midreset_first: got gid=%0d sel=%b want 0 1", grant_id, M_PSELx);
        end
        S_PSELx = '0;
        for (int c = 0; c < 15 && busy; c++) step;
        step;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_drain: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_random;
        int mph = 0;
        int mg = 0;
        int mlast = NM - 1;
        int mcnt = 0;
        int mws = 0;
        logic [AW-1:0] e_addr = '0;
        logic [DW-1:0] e_wd = '0;
        logic e_wr = 1'b0;
        logic exp_done;
        logic [NM-1:0] exp_rdy;
        logic [NM*DW-1:0] exp_rd;
        reset = 1'b0;
        S_PSELx = '0;
        step;
        reset = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            exp_done = (mph == 2) && (mcnt == mws);
            exp_rdy = exp_done ? (NM'(1) << mg) : '0;
            exp_rd = exp_done ? ({{(NM*DW-DW){1'b0}}, rd_pat} << (mg * DW)) : '0;
            checks++;
            if (busy !== (mph != 0) || {M_PSELx, M_PENABLE} !== {mph != 0, mph == 2} || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL rnd_ctl @%0d: got busy=%b sel/en=%b terr=%b want %b %b%b 0",
                         c, busy, {M_PSELx, M_PENABLE}, timeout_err, mph != 0, mph != 0, mph == 2);
            end
            checks++;
            if (grant_id !== 2'(mg)) begin
                errors++;
                $display("FAIL rnd_gid @%0d: got %0d want %0d", c, grant_id, mg);
            end
            if (mph != 0) begin
                checks++;
                if (M_PADDR !== e_addr || M_PWRITE !== e_wr || M_PWDATA !== e_wd) begin
                    errors++;
                    $display("FAIL rnd_mbus @%0d: got %h %b %h want %h %b %h", c, M_PADDR, M_PWRITE, M_PWDATA, e_addr, e_wr, e_wd);
                end
            end
            checks++;
            if (S_PREADY !== exp_rdy || S_PRDATA !== exp_rd) begin
                errors++;
                $display("FAIL rnd_slave @%0d: got pready=%b prdata=%h want %b %h", c, S_PREADY, S_PRDATA, exp_rdy, exp_rd);
            end
            for (int i = 0; i < NM; i++) begin
                if (exp_rdy[i]) S_PSELx[i] = 1'b0;
                else if (!S_PSELx[i] && $urandom_range(0, 3) == 0) S_PSELx[i] = 1'b1;
                S_PADDR[i*AW +: AW] = $urandom;
                S_PWDATA[i*DW +: DW] = $urandom;
                S_PWRITE[i] = 1'($urandom);
            end
            S_PENABLE = 4'($urandom);
            ws_next = $urandom_range(0, 3);
            rd_pat = $urandom;
            if (mph == 0) begin
                if (S_PSELx != '0) begin
                    mg = rr_pick(S_PSELx, mlast);
                    mlast = mg;
                    e_addr = S_PADDR[mg*AW +: AW];
                    e_wd = S_PWDATA[mg*DW +: DW];
                    e_wr = S_PWRITE[mg];
                    mph = 1;
                end
            end else if (mph == 1) begin
                mph = 2;
                mcnt = 0;
                mws = ws_next;
            end else if (mcnt == mws) begin
                mph = 0;
            end else begin
                mcnt++;
            end
            step;
        end
        S_PSELx = '0;
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_all_four;
        test_alternation;
        test_wait_write;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
